// File: rtl/cpu_exec_core_if.sv
// rtl/cpu_exec_core_if.sv - Control, operand and status bundle of the execution core
interface cpu_exec_core_if;
    logic       cycle_en;
    logic [7:0] instruction;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] bus_in;
    logic [7:0] state;
    logic [7:0] opcode;
    logic [3:0] cycle;
    logic [7:0] alu_out;
    logic       flag_zero;
    logic       flag_carry;
    logic [7:0] pc_out;
    logic       halted;

    modport master (
        output cycle_en, instruction, in_a, in_b, bus_in,
        input  state, opcode, cycle, alu_out, flag_zero, flag_carry, pc_out, halted
    );

    modport slave (
        input  cycle_en, instruction, in_a, in_b, bus_in,
        output state, opcode, cycle, alu_out, flag_zero, flag_carry, pc_out, halted
    );
endinterface

// File: rtl/cpu_exec_core.sv
// rtl/cpu_exec_core.sv - Micro-sequenced execution core: decode, cycle sequencer, ALU, PC
// Optional feature macro CPU_EXEC_CORE_ADC_EN makes ALU op 111 add-with-carry instead of ADD.
module cpu_exec_core (
    input  logic          clk,
    input  logic          reset,
    cpu_exec_core_if.slave bus
);
    typedef enum logic [7:0] {
        ST_NEXT       = 8'h00, ST_FETCH_PC   = 8'h01, ST_FETCH_INST = 8'h02,
        ST_HALT       = 8'h03, ST_JUMP       = 8'h04, ST_OUT        = 8'h05,
        ST_ALU_OUT    = 8'h06, ST_ALU_EXEC   = 8'h07, ST_MOV_STORE  = 8'h08,
        ST_MOV_FETCH  = 8'h09, ST_MOV_LOAD   = 8'h0A, ST_FETCH_SP   = 8'h0C,
        ST_PC_STORE   = 8'h0D, ST_TMP_JUMP   = 8'h0E, ST_RET        = 8'h0F,
        ST_INC_SP     = 8'h10, ST_SET_ADDR   = 8'h11, ST_IN         = 8'h12,
        ST_REG_STORE  = 8'h13, ST_SET_REG    = 8'h14
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'h00, OP_CALL = 8'h01, OP_RET  = 8'h02;
    localparam logic [7:0] OP_OUT  = 8'h03, OP_IN   = 8'h04, OP_HLT  = 8'h05;
    localparam logic [7:0] OP_CMP  = 8'h06, OP_LDI  = 8'h10, OP_JMP  = 8'h18;
    localparam logic [7:0] OP_PUSH = 8'h20, OP_POP  = 8'h28, OP_ALU  = 8'h40;
    localparam logic [7:0] OP_MOV  = 8'h80;

    logic [7:0] opcode;
    logic [2:0] op1, op2, alu_op;
    logic [3:0] cycle, cycle_nxt;
    state_t     cur_state;
    logic [8:0] sum9;
    logic [7:0] alu_out, pc;
    logic       flag_zero, flag_carry, jump_allowed, pc_load, pc_inc;

    assign op1 = bus.instruction[5:3];
    assign op2 = bus.instruction[2:0];

    always_comb begin
        opcode = OP_NOP;
        case (bus.instruction[7:6])
            2'b01: opcode = OP_ALU;
            2'b10: opcode = OP_MOV;
            2'b00: begin
                case (op1)
                    3'd0:    opcode = (op2 == 3'd7) ? OP_NOP : bus.instruction;
                    3'd2:    opcode = OP_LDI;
                    3'd3:    opcode = OP_JMP;
                    3'd4:    opcode = OP_PUSH;
                    3'd5:    opcode = OP_POP;
                    default: opcode = OP_NOP;
                endcase
            end
            default: opcode = OP_NOP;
        endcase
    end

    // Micro-state is a pure function of opcode and cycle; cycles 0/1 are the shared fetch.
    always_comb begin
        cur_state = ST_NEXT;
        if (cycle == 4'd0) begin
            cur_state = ST_FETCH_PC;
        end else if (cycle == 4'd1) begin
            cur_state = ST_FETCH_INST;
        end else begin
            case (opcode)
                OP_ALU:  case (cycle) 4'd2: cur_state = ST_ALU_EXEC; 4'd3: cur_state = ST_ALU_OUT; default: cur_state = ST_NEXT; endcase
                OP_CMP:  cur_state = (cycle == 4'd2) ? ST_ALU_EXEC : ST_NEXT;
                OP_LDI:  case (cycle) 4'd2: cur_state = ST_FETCH_PC; 4'd3: cur_state = ST_SET_REG; default: cur_state = ST_NEXT; endcase
                OP_JMP:  case (cycle) 4'd2: cur_state = ST_FETCH_PC; 4'd3: cur_state = ST_JUMP; default: cur_state = ST_NEXT; endcase
                OP_MOV:  case (cycle) 4'd2: cur_state = ST_MOV_FETCH; 4'd3: cur_state = ST_MOV_LOAD; 4'd4: cur_state = ST_MOV_STORE; default: cur_state = ST_NEXT; endcase
                OP_OUT:  cur_state = (cycle == 4'd2) ? ST_OUT : ST_NEXT;
                OP_IN:   cur_state = (cycle == 4'd2) ? ST_IN : ST_NEXT;
                OP_PUSH: case (cycle) 4'd2: cur_state = ST_FETCH_SP; 4'd3: cur_state = ST_REG_STORE; default: cur_state = ST_NEXT; endcase
                OP_POP:  case (cycle) 4'd2: cur_state = ST_INC_SP; 4'd3: cur_state = ST_FETCH_SP; 4'd4: cur_state = ST_SET_REG; default: cur_state = ST_NEXT; endcase
                OP_CALL: case (cycle)
                             4'd2: cur_state = ST_FETCH_PC;  4'd3: cur_state = ST_SET_ADDR;
                             4'd4: cur_state = ST_FETCH_SP;  4'd5: cur_state = ST_PC_STORE;
                             4'd6: cur_state = ST_TMP_JUMP;  default: cur_state = ST_NEXT;
                         endcase
                OP_RET:  case (cycle) 4'd2: cur_state = ST_INC_SP; 4'd3: cur_state = ST_FETCH_SP; 4'd4: cur_state = ST_RET; default: cur_state = ST_NEXT; endcase
                OP_HLT:  cur_state = ST_HALT;
                default: cur_state = ST_NEXT;
            endcase
        end
    end

    always_comb begin
        cycle_nxt = cycle;
        if (bus.cycle_en) begin
            if (cur_state == ST_NEXT)      cycle_nxt = 4'd0;
            else if (cur_state != ST_HALT) cycle_nxt = cycle + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle <= 4'd0;
        else        cycle <= cycle_nxt;
    end

    // Bit 8 of the 9-bit result is carry for add forms and borrow for subtract forms.
    always_comb begin
        alu_op = (opcode == OP_ALU) ? op1 : 3'b001;
        sum9   = 9'd0;
        case (alu_op)
            3'b000: sum9 = {1'b0, bus.in_a} + {1'b0, bus.in_b};
            3'b001: sum9 = {1'b0, bus.in_a} - {1'b0, bus.in_b};
            3'b010: sum9 = {1'b0, bus.in_a} + 9'd1;
            3'b011: sum9 = {1'b0, bus.in_a} - 9'd1;
            3'b100: sum9 = {1'b0, bus.in_a & bus.in_b};
            3'b101: sum9 = {1'b0, bus.in_a | bus.in_b};
            3'b110: sum9 = {1'b0, bus.in_a ^ bus.in_b};
`ifdef CPU_EXEC_CORE_ADC_EN
            default: sum9 = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {8'd0, flag_carry};
`else
            default: sum9 = {1'b0, bus.in_a} + {1'b0, bus.in_b};
`endif
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out    <= 8'h00;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else if (bus.cycle_en && cur_state == ST_ALU_EXEC) begin
            alu_out    <= sum9[7:0];
            flag_zero  <= (sum9[7:0] == 8'h00);
            flag_carry <= sum9[8];
        end
    end

    always_comb begin
        case (op2)
            3'b000:  jump_allowed = 1'b1;
            3'b001:  jump_allowed = flag_zero;
            3'b010:  jump_allowed = !flag_zero;
            3'b011:  jump_allowed = flag_carry;
            3'b100:  jump_allowed = !flag_carry;
            default: jump_allowed = 1'b0;
        endcase
    end

    assign pc_load = (cur_state == ST_JUMP && jump_allowed) || cur_state == ST_RET
                     || cur_state == ST_TMP_JUMP;
    assign pc_inc  = cur_state == ST_FETCH_PC
                     || (cur_state == ST_MOV_FETCH && (op1 == 3'b111 || op2 == 3'b111));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      pc <= 8'h00;
        else if (bus.cycle_en && pc_load) pc <= bus.bus_in;
        else if (bus.cycle_en && pc_inc)  pc <= pc + 8'd1;
    end

    assign bus.state      = cur_state;
    assign bus.opcode     = opcode;
    assign bus.cycle      = cycle;
    assign bus.alu_out    = alu_out;
    assign bus.flag_zero  = flag_zero;
    assign bus.flag_carry = flag_carry;
    assign bus.pc_out     = pc;
    assign bus.halted     = (cur_state == ST_HALT);
endmodule

// File: tb/tb_cpu_exec_core.sv
// tb/tb_cpu_exec_core.sv - Directed self-checking bench for cpu_exec_core
module tb_cpu_exec_core;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cpu_exec_core_if bus ();

    cpu_exec_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef CPU_EXEC_CORE_ADC_EN
    localparam logic [7:0] ADC_EXP = 8'h03;
`else
    localparam logic [7:0] ADC_EXP = 8'h02;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        reset  = 1'b0;
        bus.cycle_en    = 1'b1;
        bus.instruction = 8'h40;
        bus.in_a        = 8'h7F;
        bus.in_b        = 8'h81;
        bus.bus_in      = 8'h00;
        #12;
        chk("rst_state", bus.state, 8'h01);
        chk("rst_cycle", {4'd0, bus.cycle}, 8'h00);
        chk("rst_pc", bus.pc_out, 8'h00);
        chk("rst_alu", bus.alu_out, 8'h00);
        chk("rst_zero", {7'd0, bus.flag_zero}, 8'h00);
        chk("rst_carry", {7'd0, bus.flag_carry}, 8'h00);
        chk("rst_halted", {7'd0, bus.halted}, 8'h00);
        chk("dec_alu", bus.opcode, 8'h40);
        bus.instruction = 8'h2F; #1 chk("dec_pop", bus.opcode, 8'h28);
        bus.instruction = 8'hC3; #1 chk("dec_11_nop", bus.opcode, 8'h00);
        bus.instruction = 8'h08; #1 chk("dec_undef_nop", bus.opcode, 8'h00);
        bus.instruction = 8'h06; #1 chk("dec_cmp", bus.opcode, 8'h06);
        bus.instruction = 8'h40; #1;
        reset = 1'b1;

        tickn(1);
        chk("add_s1", bus.state, 8'h02);
        chk("add_cyc1", {4'd0, bus.cycle}, 8'h01);
        chk("add_pc1", bus.pc_out, 8'h01);
        tickn(1); chk("add_s2", bus.state, 8'h07);
        tickn(1);
        chk("add_s3", bus.state, 8'h06);
        chk("add_alu", bus.alu_out, 8'h00);
        chk("add_zero", {7'd0, bus.flag_zero}, 8'h01);
        chk("add_carry", {7'd0, bus.flag_carry}, 8'h01);
        tickn(1); chk("add_s4", bus.state, 8'h00);
        tickn(1); chk("add_wrap_cyc", {4'd0, bus.cycle}, 8'h00);

        bus.instruction = 8'h19; bus.bus_in = 8'h3C;
        tickn(3);
        chk("jz_state", bus.state, 8'h04);
        chk("jz_pc_pre", bus.pc_out, 8'h03);
        tickn(1); chk("jz_taken_pc", bus.pc_out, 8'h3C);
        tickn(1);

        bus.instruction = 8'h48; bus.in_a = 8'h03; bus.in_b = 8'h05;
        tickn(5);
        chk("sub_alu", bus.alu_out, 8'hFE);
        chk("sub_carry", {7'd0, bus.flag_carry}, 8'h01);
        chk("sub_zero", {7'd0, bus.flag_zero}, 8'h00);
        chk("sub_pc", bus.pc_out, 8'h3D);

        bus.instruction = 8'h19; bus.bus_in = 8'h10;
        tickn(5); chk("jz_not_taken_pc", bus.pc_out, 8'h3F);

        bus.instruction = 8'h06; bus.in_a = 8'h22; bus.in_b = 8'h22;
        tickn(2); chk("cmp_exec", bus.state, 8'h07);
        tickn(1);
        chk("cmp_next", bus.state, 8'h00);
        chk("cmp_zero", {7'd0, bus.flag_zero}, 8'h01);
        chk("cmp_alu", bus.alu_out, 8'h00);
        tickn(1); chk("cmp_pc", bus.pc_out, 8'h40);

        bus.instruction = 8'h48; bus.in_a = 8'h03; bus.in_b = 8'h05;
        tickn(5); chk("sub2_carry", {7'd0, bus.flag_carry}, 8'h01);
        bus.instruction = 8'h78; bus.in_a = 8'h01; bus.in_b = 8'h01;
        tickn(5);
        chk("adc_alu", bus.alu_out, ADC_EXP);
        chk("adc_carry", {7'd0, bus.flag_carry}, 8'h00);

        bus.instruction = 8'h18; bus.bus_in = 8'hFF;
        tickn(5);
        chk("jmp_pc_ff", bus.pc_out, 8'hFF);
        chk("jmp_state", bus.state, 8'h01);
        bus.cycle_en = 1'b0;
        tickn(5);
        chk("hold_cycle", {4'd0, bus.cycle}, 8'h00);
        chk("hold_pc", bus.pc_out, 8'hFF);
        chk("hold_alu", bus.alu_out, ADC_EXP);
        bus.cycle_en = 1'b1;
        tickn(1);
        chk("pc_wrap", bus.pc_out, 8'h00);
        chk("pc_wrap_cyc", {4'd0, bus.cycle}, 8'h01);
        bus.bus_in = 8'h20;
        tickn(4); chk("jmp2_pc", bus.pc_out, 8'h20);

        bus.instruction = 8'hB8;
        tickn(3);
        chk("mov_load", bus.state, 8'h0A);
        chk("mov_pc", bus.pc_out, 8'h22);
        tickn(3); chk("mov_done_cyc", {4'd0, bus.cycle}, 8'h00);

        bus.instruction = 8'h05;
        tickn(3);
        chk("hlt_state", bus.state, 8'h03);
        chk("hlt_halted", {7'd0, bus.halted}, 8'h01);
        tickn(10);
        chk("hlt_cycle", {4'd0, bus.cycle}, 8'h02);
        chk("hlt_pc", bus.pc_out, 8'h23);
        #2 reset = 1'b0;
        #1;
        chk("hlt_rst_state", bus.state, 8'h01);
        chk("hlt_rst_pc", bus.pc_out, 8'h00);
        chk("hlt_rst_halted", {7'd0, bus.halted}, 8'h00);
        #3 reset = 1'b1;
        tickn(1); chk("post_rst_cyc", {4'd0, bus.cycle}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
